// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcode/funct constants,
// ALU operation codes, trap causes and the funct -> ALUOp mapping helper.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_RTYPE    = 4'd2,
    S_RTYPEEND = 4'd3,
    S_RITYPE   = 4'd4,
    S_LW1      = 4'd5,
    S_LW2      = 4'd6,
    S_SW       = 4'd7,
    S_JALR     = 4'd8,
    S_BRANCH   = 4'd9,
    S_BRANCH2  = 4'd10,
    S_JAL      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_TIMEOUT = 2'd2
  } trap_cause_t;

  localparam int OPC_RTYPE = 0;
  localparam int OPC_ITYPE = 1;
  localparam int OPC_LDST  = 2;
  localparam int OPC_NOP   = 3;
  localparam int OPC_JAL   = 4;

  localparam logic [3:0] FN_LW       = 4'b1001;
  localparam logic [3:0] FN_SW       = 4'b1010;
  localparam logic [3:0] FN_JALR     = 4'b1011;
  localparam logic [1:0] FN_BR_PFX   = 2'b11;
  localparam logic [3:0] FN_PASS_MAX = 4'b1000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_JALR = 4'b1100;
  localparam logic [3:0] ALU_NONE = 4'b1111;

  // Low funct codes name ALU operations directly; load/store compute addresses with add.
  function automatic logic [3:0] alu_map(input logic [3:0] f);
    logic [3:0] r;
    if (f <= FN_PASS_MAX) begin
      r = f;
    end else begin
      case (f)
        FN_LW, FN_SW: r = ALU_ADD;
        ALU_JALR:     r = ALU_JALR;
        default:      r = ALU_NONE;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational funct-field decode: ALU operation and branch condition select.
module mc_alu_decode
  import mc_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 4
) (
  input  logic [FUNCT_W-1:0] funct,
  output logic [3:0]         alu_op,
  output logic [1:0]         branch_type
);

  // Map the function field onto the ALU control and branch condition.
  always_comb begin
    alu_op      = alu_map(funct[3:0]);
    branch_type = funct[1:0];
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle datapath controller with memory req/ready handshake, bounded wait timeout,
// illegal-opcode trap and stall. Define PERF_CNT_EN to add cycle/instruction counters.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W        = 3,
  parameter int FUNCT_W     = 4,
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 15
`ifdef PERF_CNT_EN
  , parameter int CNT_W     = 32
`endif
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               mem_ready,
  input  logic               stall,
  output logic               mem_req,
  output logic               mem_we,
  output logic               IoD,
  output logic               IRWrite,
  output logic               Mem2Reg,
  output logic               PCSrc,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic               Branch,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         BranchType,
  output logic [3:0]         ALUOp,
  output logic [3:0]         state,
  output logic               trap,
  output logic [1:0]         trap_cause
`ifdef PERF_CNT_EN
  , output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt
`endif
);

  state_t                 state_r;
  logic [TIMEOUT_W-1:0]   wait_cnt_r;
  trap_cause_t            cause_r;
  logic                   mem_state_s;
  logic                   timeout_s;
  logic [3:0]             dec_alu_op_s;
  logic [1:0]             dec_bt_s;
  logic                   irw_s;
  logic                   pcw_s;
  logic                   rw_s;
  logic                   we_s;

  mc_alu_decode #(.FUNCT_W(FUNCT_W)) u_alu_decode (
    .funct       (funct),
    .alu_op      (dec_alu_op_s),
    .branch_type (dec_bt_s)
  );

  assign mem_state_s = (state_r == S_FETCH) || (state_r == S_LW1) || (state_r == S_SW);
  // A ready response in the limit cycle still completes the access normally.
  assign timeout_s   = mem_state_s && !mem_ready && (wait_cnt_r == TIMEOUT_W'(MEM_TIMEOUT));

  // State, wait counter and trap cause; stall freezes all of them.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r    <= S_FETCH;
      wait_cnt_r <= '0;
      cause_r    <= CAUSE_NONE;
    end else if (!stall) begin
      wait_cnt_r <= (mem_state_s && !mem_ready) ? wait_cnt_r + TIMEOUT_W'(1) : '0;
      if (timeout_s) begin
        state_r    <= S_TRAP;
        cause_r    <= CAUSE_TIMEOUT;
        wait_cnt_r <= '0;
      end else begin
        case (state_r)
          S_FETCH:  if (mem_ready) state_r <= S_DECODE;
          S_DECODE: begin
            case (op)
              OP_W'(OPC_RTYPE): state_r <= S_RTYPE;
              OP_W'(OPC_ITYPE): begin
                if (funct[3:0] == FN_JALR)        state_r <= S_JALR;
                else if (funct[3:2] == FN_BR_PFX) state_r <= S_BRANCH;
                else                              state_r <= S_RITYPE;
              end
              OP_W'(OPC_LDST):  state_r <= S_RITYPE;
              OP_W'(OPC_NOP):   state_r <= S_FETCH;
              OP_W'(OPC_JAL):   state_r <= S_JAL;
              default: begin
                state_r <= S_TRAP;
                cause_r <= CAUSE_ILLEGAL;
              end
            endcase
          end
          S_RTYPE:  state_r <= S_RTYPEEND;
          S_RITYPE: begin
            if (funct[3:0] == FN_LW)      state_r <= S_LW1;
            else if (funct[3:0] == FN_SW) state_r <= S_SW;
            else                          state_r <= S_RTYPEEND;
          end
          S_LW1:    if (mem_ready) state_r <= S_LW2;
          S_SW:     if (mem_ready) state_r <= S_FETCH;
          S_BRANCH: state_r <= S_BRANCH2;
          S_RTYPEEND, S_LW2, S_JALR, S_JAL, S_BRANCH2: state_r <= S_FETCH;
          S_TRAP:   state_r <= S_TRAP;
          default:  state_r <= S_FETCH;
        endcase
      end
    end
  end

  // Control decode from the current state; everything is forced idle during Reset.
  always_comb begin
    mem_req    = 1'b0;
    IoD        = 1'b0;
    Mem2Reg    = 1'b0;
    PCSrc      = 1'b0;
    Branch     = 1'b0;
    ALUSrcA    = 2'd0;
    ALUSrcB    = 2'd0;
    BranchType = 2'd0;
    ALUOp      = ALU_NONE;
    state      = 4'd0;
    trap       = 1'b0;
    trap_cause = 2'd0;
    irw_s      = 1'b0;
    pcw_s      = 1'b0;
    rw_s       = 1'b0;
    we_s       = 1'b0;
    if (!Reset) begin
      state      = state_r;
      trap_cause = cause_r;
      case (state_r)
        S_FETCH: begin
          mem_req = 1'b1;
          ALUSrcB = 2'd1;
          ALUOp   = ALU_ADD;
          irw_s   = mem_ready;
          pcw_s   = mem_ready;
        end
        S_RTYPE: begin
          ALUSrcA = 2'd2;
          ALUOp   = dec_alu_op_s;
        end
        S_RTYPEEND: rw_s = 1'b1;
        S_RITYPE: begin
          ALUSrcA    = 2'd2;
          ALUSrcB    = 2'd2;
          Branch     = 1'b1;
          BranchType = dec_bt_s;
          ALUOp      = dec_alu_op_s;
        end
        S_LW1: begin
          mem_req = 1'b1;
          IoD     = 1'b1;
        end
        S_LW2: begin
          Mem2Reg = 1'b1;
          rw_s    = 1'b1;
        end
        S_SW: begin
          mem_req = 1'b1;
          IoD     = 1'b1;
          we_s    = 1'b1;
        end
        S_JALR: begin
          ALUOp   = ALU_JALR;
          ALUSrcA = 2'd3;
          ALUSrcB = 2'd2;
          rw_s    = 1'b1;
        end
        S_JAL: begin
          ALUOp   = ALU_ADD;
          ALUSrcA = 2'd3;
          ALUSrcB = 2'd1;
          pcw_s   = 1'b1;
        end
        S_BRANCH: begin
          ALUOp      = ALU_ADD;
          ALUSrcB    = 2'd2;
          Branch     = 1'b1;
          BranchType = dec_bt_s;
        end
        S_BRANCH2: begin
          ALUOp      = ALU_SUB;
          ALUSrcA    = 2'd2;
          Branch     = 1'b1;
          PCSrc      = 1'b1;
          pcw_s      = 1'b1;
          BranchType = dec_bt_s;
        end
        S_TRAP:  trap = 1'b1;
        default: ALUOp = ALU_NONE;
      endcase
    end else begin
      ALUOp = ALU_NONE;
    end
  end

  // Architectural write enables must never fire while the FSM is held.
  assign IRWrite  = irw_s & ~stall;
  assign PCWrite  = pcw_s & ~stall;
  assign RegWrite = rw_s  & ~stall;
  assign mem_we   = we_s  & ~stall;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_r;
  logic [CNT_W-1:0] instr_cnt_r;
  logic             instr_done_s;

  assign instr_done_s = !stall && ((state_r == S_RTYPEEND) || (state_r == S_LW2) ||
                        (state_r == S_JALR) || (state_r == S_JAL) || (state_r == S_BRANCH2) ||
                        ((state_r == S_SW) && mem_ready) ||
                        ((state_r == S_DECODE) && (op == OP_W'(OPC_NOP))));

  // Free-running performance counters, frozen once trapped.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cycle_cnt_r <= '0;
      instr_cnt_r <= '0;
    end else if (state_r != S_TRAP) begin
      cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
      if (instr_done_s) instr_cnt_r <= instr_cnt_r + CNT_W'(1);
    end
  end

  assign cycle_cnt = Reset ? '0 : cycle_cnt_r;
  assign instr_cnt = Reset ? '0 : instr_cnt_r;
`endif

endmodule
